spine_ingress_tagger: RTL and testbench
=======================================

# spine_ingress_tagger

Ingress-side companion of the spine routing table: where the routing table maps a destination address to an output port, this block maps the ingress port a flit arrived on back to a 6-bit source address {GroupID[3:0], LeafID[1:0]}. It sits between each spine's ingress crossbar and its routing table. It stamps every accepted flit with the source address that response traffic must be routed back to, and drops flits arriving on non-existent ports. It buffers flits in a 2-entry FIFO with valid/ready handshakes on both sides.

## Interface
- GROUP_ID, 4'b0111, group number of the spine hosting this block (legal 1..8).
- DATA_W, 32, payload width in bits.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  ingress flit valid.
- in_ready  output  1  tagger can accept a flit.
- in_port  input  4  ingress port number (encoding below).
- in_src_leaf  input  2  source leaf carried by the flit; used only for spine-link ports.
- in_dest  input  6  destination address, passed through unchanged.
- in_data  input  DATA_W  payload, passed through unchanged.
- out_valid  output  1  tagged flit valid.
- out_ready  input  1  downstream (routing stage) accepts.
- out_src  output  6  reconstructed source address.
- out_dest  output  6  forwarded destination.
- out_data  output  DATA_W  forwarded payload.
- drop_cnt  output  8  saturating count of dropped flits.

## Operation
- Port decode:
  - ports 4'b0001..4'b0100 are local leaves: out_src = {GROUP_ID, in_port-1}.
  - ports 4'b0101..4'b1011 are spine links to the seven other groups, in ascending group order with GROUP_ID skipped; the k-th link (k=0..6) maps to the k-th group of {1..8}\{GROUP_ID}. out_src = {that group, in_src_leaf}.
  - ports 4'b0000 and 4'b1100..4'b1111 are invalid.
- Handshake: transfer occurs when valid && ready on a side in the same cycle. Once out_valid is asserted, out_* stays stable until the transfer completes.
- Valid flit on accept: the tagged entry is pushed to the FIFO.
- Invalid-port flit on accept: the flit is consumed and discarded, nothing is pushed, and drop_cnt increments (saturates at 8'hFF, no wrap).
- FIFO: depth 2, count in 0..2; out_* always show the head entry; ordering is strictly preserved.
- in_ready = (count != 2), decoded from registered count only. There is no combinational path from out_ready to in_ready.
- Simultaneous push and pop: count is unchanged. This is legal at count 1; at count 2 there is no push because in_ready=0.
- Pop at count 0 cannot occur (out_valid=0).

## Timing
- Reset values: out_valid=0, in_ready=1 (count=0), drop_cnt=0, out_src/out_dest/out_data=0. FIFO pointers are cleared.
- Reset mid-operation: buffered flits are discarded and not delivered; the following cycle matches post-reset state.
- Latency: a flit accepted in cycle N presents out_valid=1 in cycle N+1 when the FIFO was empty. Otherwise it presents after the entries ahead of it have been popped.
- Throughput: 1 flit/cycle sustained with out_ready held high.
- drop_cnt updates in the cycle after the dropping accept.
- Decode is registered with the entry; in_port need not be held after the accept.

## Configuration
- SPINE_TAG_DROP_CNT_EN defined: the drop counter is implemented as described.
- SPINE_TAG_DROP_CNT_EN undefined: the counter logic is removed and drop_cnt is tied to 8'h00. Invalid-port flits are still accepted and discarded.

## Test plan
- GROUP_ID=7, in_port=4'b0011, in_dest=6'b000101, in_data=32'hA5A5_0001, out_ready=1 -> next cycle out_valid=1, out_src=6'b011110, out_dest=6'b000101, out_data=32'hA5A5_0001.
- Spine ports with in_src_leaf=2'b10: port 4'b0101 -> out_src=6'b000110; port 4'b1010 -> 6'b011010 (group 6); port 4'b1011 -> 6'b100010 (group 8).
- in_port=4'b0000, then 4'b1111 -> both consumed (in_ready=1), no out_valid, drop_cnt=2. Then 300 invalid flits -> drop_cnt=8'hFF.
- Backpressure: out_ready=0 while 3 flits are offered -> 2 accepted, in_ready=0 on the 3rd and out_* stable. Raise out_ready -> flits delivered in order and the 3rd accepted one cycle after the first pop.
- Streaming: out_ready=1, 10 back-to-back valid flits -> 10 outputs on consecutive cycles with matching order and tags.
- rst asserted for 1 cycle with 2 flits buffered -> next cycle out_valid=0, in_ready=1, drop_cnt=0, and neither flit ever appears.

Source files
------------

// File: rtl/spine_ingress_tagger_if.sv
// ============================================================================
// Module      : spine_ingress_tagger_if
// Description : Ingress and egress flit handshake bundle for the spine tagger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spine_ingress_tagger_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_port;
    logic [1:0]        in_src_leaf;
    logic [5:0]        in_dest;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_src;
    logic [5:0]        out_dest;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_port, in_src_leaf, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_src, out_dest, out_data
    );

    modport slave (
        input  in_valid, in_port, in_src_leaf, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_src, out_dest, out_data
    );
endinterface

`default_nettype wire

// File: rtl/spine_ingress_tagger.sv
// ============================================================================
// Module      : spine_ingress_tagger
// Description : Stamps ingress flits with a 6-bit source address derived from
//               the ingress port, drops flits from non-existent ports, and
//               buffers tagged flits in a 2-entry FIFO. Optional drop counter
//               is enabled by defining SPINE_TAG_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spine_ingress_tagger #(
    parameter logic [3:0] GROUP_ID = 4'b0111,
    parameter int         DATA_W   = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    spine_ingress_tagger_if.slave       bus,
    output      logic [7:0]             drop_cnt
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic              w_port_ok;
    logic [5:0]        w_tag_src;
    logic [3:0]        w_link_grp;
    logic [1:0]        w_leaf_idx;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    logic [1:0]        count_q,    count_d;
    logic              wr_ptr_q,   wr_ptr_d;
    logic              rd_ptr_q,   rd_ptr_d;
    logic [5:0]        src_mem_q  [2];
    logic [5:0]        src_mem_d  [2];
    logic [5:0]        dest_mem_q [2];
    logic [5:0]        dest_mem_d [2];
    logic [DATA_W-1:0] data_mem_q [2];
    logic [DATA_W-1:0] data_mem_d [2];

    // Spine links enumerate the other seven groups in ascending order, so the
    // link index (port-4 gives 1..7) is bumped by one once it reaches our group.
    always_comb begin
        w_port_ok  = 1'b0;
        w_tag_src  = '0;
        w_leaf_idx = bus.in_port[1:0] - 2'd1;
        w_link_grp = bus.in_port - 4'd4;
        if (w_link_grp >= GROUP_ID) begin
            w_link_grp = w_link_grp + 4'd1;
        end
        if (bus.in_port >= 4'd1 && bus.in_port <= 4'd4) begin
            w_port_ok = 1'b1;
            w_tag_src = {GROUP_ID, w_leaf_idx};
        end else if (bus.in_port >= 4'd5 && bus.in_port <= 4'd11) begin
            w_port_ok = 1'b1;
            w_tag_src = {w_link_grp, bus.in_src_leaf};
        end
    end

    assign bus.in_ready  = (count_q != c_FULL);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_src   = src_mem_q[rd_ptr_q];
    assign bus.out_dest  = dest_mem_q[rd_ptr_q];
    assign bus.out_data  = data_mem_q[rd_ptr_q];

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = w_accept && w_port_ok;
    assign w_drop   = w_accept && !w_port_ok;
    assign w_pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        src_mem_d  = src_mem_q;
        dest_mem_d = dest_mem_q;
        data_mem_d = data_mem_q;
        if (w_push) begin
            src_mem_d[wr_ptr_q]  = w_tag_src;
            dest_mem_d[wr_ptr_q] = bus.in_dest;
            data_mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            src_mem_q  <= '{default: '0};
            dest_mem_q <= '{default: '0};
            data_mem_q <= '{default: '0};
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            src_mem_q  <= src_mem_d;
            dest_mem_q <= dest_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

`ifdef SPINE_TAG_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Invalid-port flits are still consumed; only the count is absent.
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
    assign drop_cnt      = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spine_ingress_tagger.sv
// ============================================================================
// Module      : tb_spine_ingress_tagger
// Description : Self-checking bench for spine_ingress_tagger against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spine_ingress_tagger;

    localparam logic [3:0] GID = 4'b0111;
    localparam int         DW  = 32;
`ifdef SPINE_TAG_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]    src;
        logic [5:0]    dest;
        logic [DW-1:0] data;
    } flit_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drop_cnt;

    spine_ingress_tagger_if #(.DATA_W(DW)) bus ();

    spine_ingress_tagger #(.GROUP_ID(GID), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    flit_t mq[$];
    int    m_drop;
    int    checks;
    int    errors;

    // Source address from the port rules: local leaves keep our group,
    // spine links index the list of the other seven groups.
    function automatic bit ref_src(input logic [3:0] port, input logic [1:0] leaf,
                                   output logic [5:0] src);
        int groups[$];
        int p;
        p = int'(port);
        for (int g = 1; g <= 8; g++) if (g != int'(GID)) groups.push_back(g);
        src = '0;
        if (p >= 1 && p <= 4) begin
            src = {GID, 2'(p - 1)};
            return 1'b1;
        end
        if (p >= 5 && p <= 11) begin
            src = {4'(groups[p - 5]), leaf};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called at a falling edge: drives inputs, advances the model across the
    // next rising edge, and returns at the following falling edge.
    task automatic drive_cycle(input bit v, input logic [3:0] p, input logic [1:0] l,
                               input logic [5:0] d, input logic [DW-1:0] dat,
                               input bit ordy);
        bit         acc, pop, ok;
        logic [5:0] s;
        bus.in_valid    = v;
        bus.in_port     = p;
        bus.in_src_leaf = l;
        bus.in_dest     = d;
        bus.in_data     = dat;
        bus.out_ready   = ordy;
        acc = v && (mq.size() < 2);
        pop = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_drop = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                ok = ref_src(p, l, s);
                if (ok) mq.push_back({s, d, dat});
                else if (CNT_EN && m_drop < 255) m_drop++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++;
        if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 00", drop_cnt); end
        checks++;
        if ({bus.out_src, bus.out_dest, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_out_fields: got %h/%h/%h expected 0", bus.out_src, bus.out_dest, bus.out_data);
        end
    endtask

    task automatic test_local_port();
        drive_cycle(1'b1, 4'b0011, 2'b00, 6'b000101, 32'hA5A5_0001, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== 6'b011110 || bus.out_dest !== 6'b000101 ||
            bus.out_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL local_port: got v=%b src=%b dest=%b data=%h expected v=1 src=011110 dest=000101 data=a5a50001",
                     bus.out_valid, bus.out_src, bus.out_dest, bus.out_data);
        end
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL local_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_spine_ports();
        logic [3:0]    ports [3] = '{4'b0101, 4'b1010, 4'b1011};
        logic [5:0]    exp   [3] = '{6'b000110, 6'b011010, 6'b100010};
        logic [DW-1:0] dat;
        for (int i = 0; i < 3; i++) begin
            dat = $urandom;
            drive_cycle(1'b1, ports[i], 2'b10, 6'(i), dat, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_src !== exp[i] || bus.out_data !== dat) begin
                errors++;
                $display("FAIL spine_port_%0d: got v=%b src=%b data=%h expected v=1 src=%b data=%h",
                         i, bus.out_valid, bus.out_src, bus.out_data, exp[i], dat);
            end
        end
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
    endtask

    task automatic test_invalid_ports();
        logic [3:0] bad [5] = '{4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
        drive_cycle(1'b1, 4'b0000, 2'd0, 6'd1, 32'h1, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_port0: got rdy=%b v=%b expected rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
        drive_cycle(1'b1, 4'b1111, 2'd0, 6'd2, 32'h2, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || drop_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL invalid_two: got v=%b drop=%0d expected v=0 drop=%0d",
                     bus.out_valid, drop_cnt, CNT_EN ? 2 : 0);
        end
        for (int i = 0; i < 300; i++)
            drive_cycle(1'b1, bad[$urandom_range(0, 4)], 2'($urandom), 6'($urandom), $urandom, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || drop_cnt !== (CNT_EN ? 8'hFF : 8'h00) || drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL invalid_saturate: got v=%b drop=%h expected v=0 drop=%h",
                     bus.out_valid, drop_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]    p   [3];
        logic [1:0]    l   [3];
        logic [5:0]    d   [3];
        logic [DW-1:0] dat [3];
        logic [5:0]    s   [3];
        for (int i = 0; i < 3; i++) begin
            p[i] = 4'($urandom_range(1, 11)); l[i] = 2'($urandom);
            d[i] = 6'($urandom); dat[i] = $urandom;
            void'(ref_src(p[i], l[i], s[i]));
        end
        drive_cycle(1'b1, p[0], l[0], d[0], dat[0], 1'b0);
        drive_cycle(1'b1, p[1], l[1], d[1], dat[1], 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            {bus.out_src, bus.out_dest, bus.out_data} !== {s[0], d[0], dat[0]}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b head=%h/%h/%h expected rdy=0 v=1 head=%h/%h/%h",
                     bus.in_ready, bus.out_valid, bus.out_src, bus.out_dest, bus.out_data, s[0], d[0], dat[0]);
        end
        drive_cycle(1'b1, p[2], l[2], d[2], dat[2], 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || {bus.out_src, bus.out_dest, bus.out_data} !== {s[0], d[0], dat[0]}) begin
            errors++;
            $display("FAIL bp_stable: got rdy=%b head=%h/%h/%h expected rdy=0 head=%h/%h/%h",
                     bus.in_ready, bus.out_src, bus.out_dest, bus.out_data, s[0], d[0], dat[0]);
        end
        drive_cycle(1'b1, p[2], l[2], d[2], dat[2], 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1 || {bus.out_src, bus.out_dest, bus.out_data} !== {s[1], d[1], dat[1]}) begin
            errors++;
            $display("FAIL bp_first_pop: got rdy=%b head=%h/%h/%h expected rdy=1 head=%h/%h/%h",
                     bus.in_ready, bus.out_src, bus.out_dest, bus.out_data, s[1], d[1], dat[1]);
        end
        drive_cycle(1'b1, p[2], l[2], d[2], dat[2], 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_src, bus.out_dest, bus.out_data} !== {s[2], d[2], dat[2]}) begin
            errors++;
            $display("FAIL bp_third: got v=%b head=%h/%h/%h expected v=1 head=%h/%h/%h",
                     bus.out_valid, bus.out_src, bus.out_dest, bus.out_data, s[2], d[2], dat[2]);
        end
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]    p;
        logic [1:0]    l;
        logic [5:0]    d, s;
        logic [DW-1:0] dat;
        for (int i = 0; i < 10; i++) begin
            p = 4'($urandom_range(1, 11)); l = 2'($urandom); d = 6'($urandom); dat = $urandom;
            void'(ref_src(p, l, s));
            drive_cycle(1'b1, p, l, d, dat, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
                {bus.out_src, bus.out_dest, bus.out_data} !== {s, d, dat}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b rdy=%b head=%h/%h/%h expected v=1 rdy=1 head=%h/%h/%h",
                         i, bus.out_valid, bus.in_ready, bus.out_src, bus.out_dest, bus.out_data, s, d, dat);
            end
        end
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
    endtask

    task automatic test_random();
        flit_t h;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 6'($urandom),
                        $urandom, $urandom_range(0, 2) != 0);
            checks++;
            h = (mq.size() > 0) ? mq[0] : '0;
            if (bus.out_valid !== (mq.size() > 0) || bus.in_ready !== (mq.size() < 2) ||
                drop_cnt !== 8'(m_drop) ||
                (mq.size() > 0 && {bus.out_src, bus.out_dest, bus.out_data} !== h)) begin
                errors++;
                $display("FAIL random_%0d: got v=%b rdy=%b drop=%h head=%h/%h/%h expected v=%b rdy=%b drop=%h head=%h",
                         i, bus.out_valid, bus.in_ready, drop_cnt, bus.out_src, bus.out_dest, bus.out_data,
                         mq.size() > 0, mq.size() < 2, 8'(m_drop), h);
            end
        end
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b1, 4'd2, 2'd0, 6'h11, 32'hDEAD_0001, 1'b0);
        drive_cycle(1'b1, 4'd6, 2'd1, 6'h22, 32'hDEAD_0002, 1'b0);
        drive_cycle(1'b1, 4'd0, 2'd0, 6'h00, 32'h0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mrst_pre: got v=%b rdy=%b expected v=1 rdy=0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b0);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || drop_cnt !== 8'h00 ||
            {bus.out_src, bus.out_dest, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL mrst_post: got v=%b rdy=%b drop=%h head=%h/%h/%h expected v=0 rdy=1 drop=00 head=0",
                     bus.out_valid, bus.in_ready, drop_cnt, bus.out_src, bus.out_dest, bus.out_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mrst_ghost_%0d: got v=%b expected 0", i, bus.out_valid);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; m_drop = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_port = '0; bus.in_src_leaf = '0;
        bus.in_dest = '0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b0);
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, '0, 1'b0);
        rst = 1'b0;
        test_reset();
        test_local_port();
        test_spine_ports();
        test_invalid_ports();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
